// File: rtl/gemv_tile_sequencer.sv
// Tile sequencer for y = W*x on recfg_array (MAC mode): walks row/column blocks, feeds the
// partial-sum buffer back as acc_in, then streams y out. Define GEMV_SEQ_TIMEOUT_EN for a WAIT watchdog.
module gemv_tile_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int TILE_SIZE      = 16,
    parameter int OUT_SIZE       = 40,
    parameter int D_INNER        = 256,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int N_ROWBLK = (OUT_SIZE + TILE_SIZE - 1) / TILE_SIZE,
    localparam int N_COLBLK = D_INNER / TILE_SIZE,
    localparam int RB_W     = (N_ROWBLK > 1) ? $clog2(N_ROWBLK) : 1,
    localparam int CB_W     = (N_COLBLK > 1) ? $clog2(N_COLBLK) : 1,
    localparam int IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             tile_req,
    output logic [RB_W-1:0]                  tile_rb,
    output logic [CB_W-1:0]                  tile_cb,
    input  logic                             tile_ack,
    output logic [2:0]                       arr_mode,
    output logic                             arr_valid_in,
    output logic                             arr_accumulate_en,
    output logic [TILE_SIZE*DATA_WIDTH-1:0]  arr_acc_in_vec,
    input  logic                             arr_done_tile,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0]  arr_result_out_vec,
    output logic                             y_valid,
    input  logic                             y_ready,
    output logic [IDX_W-1:0]                 y_idx,
    output logic [DATA_WIDTH-1:0]            y_data
);

    // state   | meaning
    // IDLE    | waiting for start
    // REQ     | tile_req high until loader acks (rb, cb)
    // FEED    | TILE_SIZE cycles of arr_valid_in
    // WAIT    | waiting for arr_done_tile, then capture and advance
    // DRAIN   | streaming y[0..OUT_SIZE-1]
    // DONE    | one-cycle done pulse
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int FC_W = $clog2(TILE_SIZE + 1);
    localparam logic [RB_W-1:0]  RB_LAST  = RB_W'(N_ROWBLK - 1);
    localparam logic [CB_W-1:0]  CB_LAST  = CB_W'(N_COLBLK - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_SIZE - 1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [FC_W-1:0]       feed_cnt;
    logic [DATA_WIDTH-1:0] psum [OUT_SIZE];
    logic                  psum_we;
    logic                  timeout;

`ifdef GEMV_SEQ_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WC_W-1:0] wait_cnt;

    // Reloaded throughout FEED so it starts full on every entry to WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_FEED) begin
            wait_cnt <= WC_W'(TIMEOUT_CYCLES - 1);
        end else if (state == S_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign timeout = (state == S_WAIT) && !arr_done_tile && (wait_cnt == '0);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign psum_we = (state == S_WAIT) && arr_done_tile;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_REQ;
            S_REQ:   if (tile_ack) state_nxt = S_FEED;
            S_FEED:  if (feed_cnt == '0) state_nxt = S_WAIT;
            S_WAIT: begin
                if (timeout) begin
                    state_nxt = S_IDLE;
                end else if (arr_done_tile) begin
                    state_nxt = (tile_cb == CB_LAST && tile_rb == RB_LAST) ? S_DRAIN : S_REQ;
                end
            end
            S_DRAIN: if (y_ready && y_idx == IDX_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            feed_cnt <= '0;
            tile_rb  <= '0;
            tile_cb  <= '0;
            y_idx    <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && start) begin
                tile_rb <= '0;
                tile_cb <= '0;
                y_idx   <= '0;
                err     <= 1'b0;
            end

            if (state == S_REQ) begin
                feed_cnt <= FC_W'(TILE_SIZE - 1);
            end else if (state == S_FEED && feed_cnt != '0) begin
                feed_cnt <= feed_cnt - 1'b1;
            end

            // A tile-complete pulse while still feeding is a protocol error; the pulse is dropped.
            if ((state == S_FEED && arr_done_tile) || timeout) begin
                err <= 1'b1;
            end

            if (psum_we) begin
                if (tile_cb != CB_LAST) begin
                    tile_cb <= tile_cb + 1'b1;
                end else begin
                    tile_cb <= '0;
                    tile_rb <= (tile_rb != RB_LAST) ? tile_rb + 1'b1 : '0;
                end
            end

            if (state == S_DRAIN && y_ready) begin
                y_idx <= (y_idx == IDX_LAST) ? '0 : y_idx + 1'b1;
            end
        end
    end

    // Partial sums are not reset; padding rows beyond OUT_SIZE have no storage.
    always_ff @(posedge clk) begin
        if (psum_we) begin
            for (int r = 0; r < OUT_SIZE; r++) begin
                if (tile_rb == RB_W'(r / TILE_SIZE)) begin
                    psum[r] <= arr_result_out_vec[(r % TILE_SIZE)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);
    assign tile_req          = (state == S_REQ);
    assign arr_valid_in      = (state == S_FEED);
    assign arr_mode          = 3'b000;
    assign y_valid           = (state == S_DRAIN);
    assign arr_accumulate_en = (state == S_REQ || state == S_FEED || state == S_WAIT)
                               && (tile_cb != '0);

    always_comb begin
        arr_acc_in_vec = '0;
        y_data         = '0;
        for (int r = 0; r < OUT_SIZE; r++) begin
            if (arr_accumulate_en && tile_rb == RB_W'(r / TILE_SIZE)) begin
                arr_acc_in_vec[(r % TILE_SIZE)*DATA_WIDTH +: DATA_WIDTH] = psum[r];
            end
            if (y_valid && y_idx == IDX_W'(r)) begin
                y_data = psum[r];
            end
        end
    end

endmodule

// File: tb/tb_gemv_tile_sequencer.sv
// Scoreboard bench for gemv_tile_sequencer: loader/array model, expected tiles and y in queues.
module tb_gemv_tile_sequencer;
    localparam int DW  = 16;
    localparam int TS  = 16;
    localparam int OS  = 40;
    localparam int DI  = 256;
    localparam int NRB = 3;
    localparam int NCB = 16;
    localparam int TO  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic tile_ack = 1'b0;
    logic arr_done_tile = 1'b0;
    logic y_ready = 1'b0;
    logic [TS*DW-1:0] arr_result_out_vec = '0;
    logic busy, done, err, tile_req;
    logic [1:0] tile_rb;
    logic [3:0] tile_cb;
    logic [2:0] arr_mode;
    logic arr_valid_in, arr_accumulate_en;
    logic [TS*DW-1:0] arr_acc_in_vec;
    logic y_valid;
    logic [5:0] y_idx;
    logic [DW-1:0] y_data;

    gemv_tile_sequencer #(
        .DATA_WIDTH(DW), .TILE_SIZE(TS), .OUT_SIZE(OS), .D_INNER(DI), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .tile_req(tile_req), .tile_rb(tile_rb), .tile_cb(tile_cb), .tile_ack(tile_ack),
        .arr_mode(arr_mode), .arr_valid_in(arr_valid_in), .arr_accumulate_en(arr_accumulate_en),
        .arr_acc_in_vec(arr_acc_in_vec), .arr_done_tile(arr_done_tile),
        .arr_result_out_vec(arr_result_out_vec), .y_valid(y_valid), .y_ready(y_ready),
        .y_idx(y_idx), .y_data(y_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] w [OS][DI];
    logic [15:0] x [DI];
    logic [15:0] yref [OS];
    int exp_tile [$];
    int exp_y [$];

    int cur_rb, cur_cb, run, lat, xfers, dones, cyc, feed_end_cyc, busy_fall_cyc;
    logic cap_en;
    logic [TS*DW-1:0] cap_acc;
    bit pend, req_seen, stalled, exp_done, rtoggle, prev_busy;
    bit ready_alt, inject, silent;
    logic [5:0] h_idx;
    logic [15:0] h_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [TS*DW-1:0] model_res();
        logic [TS*DW-1:0] res;
        logic [15:0] s;
        int row;
        res = '0;
        for (int i = 0; i < TS; i++) begin
            row = cur_rb * TS + i;
            if (row >= OS) begin
                res[i*DW +: DW] = 16'h7FFF;
            end else begin
                s = cap_en ? cap_acc[i*DW +: DW] : 16'h0000;
                for (int c = cur_cb * TS; c < cur_cb * TS + TS; c++) s = s + w[row][c] * x[c];
                res[i*DW +: DW] = s;
            end
        end
        return res;
    endfunction

    // Loader, array and y-sink model; samples 1 time unit after each rising edge.
    initial begin
        int t;
        bit ry;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                tile_ack = 0; arr_done_tile = 0; y_ready = 0;
                run = 0; pend = 0; req_seen = 0; stalled = 0; exp_done = 0; prev_busy = 0;
            end else begin
                if (exp_done) begin
                    chk("done_after_last", done, 1);
                    exp_done = 0;
                end
                if (done) dones++;
                if (prev_busy && !busy) busy_fall_cyc = cyc;
                prev_busy = busy;
                tile_ack = 0;
                arr_done_tile = 0;

                if (tile_req && !req_seen) begin
                    req_seen = 1;
                    if (exp_tile.size() > 0) begin
                        t = exp_tile.pop_front();
                        cur_rb = t / NCB;
                        cur_cb = t % NCB;
                        chk("tile_rb", tile_rb, cur_rb);
                        chk("tile_cb", tile_cb, cur_cb);
                    end else begin
                        chk("tile_req_extra", tile_req, 0);
                    end
                    tile_ack = 1;
                end
                if (!tile_req) req_seen = 0;

                if (arr_valid_in) begin
                    if (run == 0) begin
                        cap_en = arr_accumulate_en;
                        cap_acc = arr_acc_in_vec;
                        chk("acc_en", arr_accumulate_en, (cur_cb != 0));
                        for (int i = 0; i < TS; i++)
                            if (cur_rb * TS + i >= OS) chk("pad_acc_in", arr_acc_in_vec[i*DW +: DW], 0);
                    end
                    run++;
                    if (inject && run == 6) begin
                        arr_done_tile = 1;
                        arr_result_out_vec = {TS{16'hDEAD}};
                        inject = 0;
                    end
                end else if (run > 0) begin
                    chk("feed_len", run, TS);
                    run = 0;
                    feed_end_cyc = cyc;
                    if (!silent) begin
                        pend = 1;
                        lat = 2;
                    end
                end

                if (pend) begin
                    if (lat == 0) begin
                        arr_done_tile = 1;
                        arr_result_out_vec = model_res();
                        pend = 0;
                    end else begin
                        lat--;
                    end
                end

                if (y_valid) begin
                    if (stalled) begin
                        chk("y_idx_hold", y_idx, h_idx);
                        chk("y_data_hold", y_data, h_data);
                    end
                    ry = ready_alt ? rtoggle : 1'b1;
                    rtoggle = !rtoggle;
                    y_ready = ry;
                    if (ry) begin
                        stalled = 0;
                        if (exp_y.size() > 0) begin
                            t = exp_y.pop_front();
                            chk("y_idx", y_idx, t >> 16);
                            chk("y_data", y_data, t & 16'hFFFF);
                        end else begin
                            chk("y_extra", y_valid, 0);
                        end
                        xfers++;
                        if (xfers == OS) exp_done = 1;
                    end else begin
                        stalled = 1;
                        h_idx = y_idx;
                        h_data = y_data;
                    end
                end else begin
                    y_ready = 0;
                end
            end
        end
    end

    task automatic load_data(input bit rnd);
        logic [15:0] s;
        for (int c = 0; c < DI; c++) x[c] = rnd ? 16'($urandom) : 16'd2;
        for (int r = 0; r < OS; r++) begin
            s = 0;
            for (int c = 0; c < DI; c++) begin
                w[r][c] = rnd ? 16'($urandom) : 16'd1;
                s = s + w[r][c] * x[c];
            end
            yref[r] = s;
        end
    endtask

    task automatic start_gemv(input bit rnd);
        load_data(rnd);
        exp_tile.delete();
        exp_y.delete();
        for (int rb = 0; rb < NRB; rb++)
            for (int cb = 0; cb < NCB; cb++) exp_tile.push_back(rb * NCB + cb);
        for (int r = 0; r < OS; r++) exp_y.push_back((r << 16) | int'(yref[r]));
        xfers = 0;
        dones = 0;
        rtoggle = 1;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("busy_t1", busy, 1);
        chk("tile_req_t1", tile_req, 1);
        chk("err_cleared", err, 0);
    endtask

    task automatic finish_gemv(input logic exp_err);
        int n = 0;
        while ((busy || xfers < OS) && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("run_in_budget", (n < 6000), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("done_count", dones, 1);
        chk("tiles_left", exp_tile.size(), 0);
        chk("y_left", exp_y.size(), 0);
        chk("busy_idle", busy, 0);
        chk("err_end", err, exp_err);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_req"}, tile_req, 0);
        chk({tag, "_rbcb"}, {tile_rb, tile_cb}, 0);
        chk({tag, "_valid_in"}, arr_valid_in, 0);
        chk({tag, "_acc_en"}, arr_accumulate_en, 0);
        chk({tag, "_acc_in"}, |arr_acc_in_vec, 0);
        chk({tag, "_mode"}, arr_mode, 0);
        chk({tag, "_y"}, {y_valid, y_idx, y_data}, 0);
    endtask

    initial begin
        int n;
        ready_alt = 0; inject = 0; silent = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("init");
        @(negedge clk);
        rst = 0;

        // W=1, x=2: every y is 512
        start_gemv(0);
        finish_gemv(0);

        // spurious done_tile mid-FEED: err set, schedule and results unchanged
        inject = 1;
        start_gemv(0);
        finish_gemv(1);

        // backpressure with random data
        ready_alt = 1;
        start_gemv(1);
        finish_gemv(0);
        ready_alt = 0;

        // reset during FEED of tile (1,5), then a clean random run
        start_gemv(1);
        n = 0;
        while (!(arr_valid_in && tile_rb == 2'd1 && tile_cb == 4'd5) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_tile_1_5", (n < 3000), 1);
        #2 rst = 1;
        #1 check_reset("midrst");
        repeat (2) @(negedge clk);
        exp_tile.delete();
        exp_y.delete();
        rst = 0;
        start_gemv(1);
        finish_gemv(0);

`ifdef GEMV_SEQ_TIMEOUT_EN
        silent = 1;
        start_gemv(0);
        n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_in_budget", (n < 3000), 1);
        @(posedge clk); #1;
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_no_done", dones, 0);
        chk("to_wait_cycles", busy_fall_cyc - feed_end_cyc, TO);
        silent = 0;
        exp_tile.delete();
        exp_y.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
